// File: rtl/cbfp_pkg.sv
// Shared types and helpers for the CBFP stage-1 blocks.
package cbfp_pkg;

    // Default LZC / shift width used across the CBFP stage-1 blocks.
    localparam int LZC_W_DEF = 5;

    // Sideband tag that travels alongside a beat through the min-detect datapath.
    typedef struct packed {
        logic vld;    // slot carries a real beat
        logic last;   // final beat of a CBFP block
        logic first;  // opening beat of a CBFP block
    } cbfp_tag_t;

    // Unsigned minimum of two LZC values; on a tie the first operand is kept.
    function automatic logic [LZC_W_DEF-1:0] lzc_min(
        input logic [LZC_W_DEF-1:0] a,
        input logic [LZC_W_DEF-1:0] b
    );
        return (b < a) ? b : a;
    endfunction

endpackage

// File: rtl/cbfp1_min_ctrl_if.sv
// Beat/datapath/result bundle between the LZC stage, the min-detect
// datapath and the CBFP scaling stage.
interface cbfp1_min_ctrl_if
    import cbfp_pkg::*;
#(
    parameter int LZC_WIDTH = LZC_W_DEF
) ();

    logic                 valid_in;
    logic                 md_en;
    logic [LZC_WIDTH-1:0] md_min_add;
    logic [LZC_WIDTH-1:0] md_min_sub;
    logic                 blk_valid;
    logic [LZC_WIDTH-1:0] blk_shift_add;
    logic [LZC_WIDTH-1:0] blk_shift_sub;
    logic [7:0]           blk_idx;
    logic                 busy;

    // Sequencer side.
    modport slave (
        input  valid_in,
        input  md_min_add,
        input  md_min_sub,
        output md_en,
        output blk_valid,
        output blk_shift_add,
        output blk_shift_sub,
        output blk_idx,
        output busy
    );

    // Beat source / datapath / result consumer side.
    modport master (
        output valid_in,
        output md_min_add,
        output md_min_sub,
        input  md_en,
        input  blk_valid,
        input  blk_shift_add,
        input  blk_shift_sub,
        input  blk_idx,
        input  busy
    );

endinterface

// File: rtl/cbfp1_tag_pipe.sv
// PIPE_LAT-deep tag shift register that advances in lock-step with the
// min-detect datapath, so the tail tag always describes the datapath output.
module cbfp1_tag_pipe
    import cbfp_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      clr,
    input  logic      en,
    input  cbfp_tag_t tag_in,
    output cbfp_tag_t tag_tail,
    output logic      any_vld
);

    cbfp_tag_t [PIPE_LAT-1:0] stg;

    // Shift on enabled edges; a soft clear empties every slot regardless of enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg <= '0;
        end else if (clr) begin
            stg <= '0;
        end else if (en) begin
            stg[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign tag_tail = stg[PIPE_LAT-1];

    // Any occupied slot keeps the datapath enabled so it drains by itself.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            any_vld = any_vld | stg[i].vld;
        end
    end

endmodule

// File: rtl/cbfp1_min_ctrl.sv
// CBFP stage-1 min-detect sequencer: enables the datapath, tags beats with
// their block position and folds per-beat minima into one shift per block.
module cbfp1_min_ctrl
    import cbfp_pkg::*;
#(
    parameter int LZC_WIDTH = LZC_W_DEF,
    parameter int BLK_BEATS = 4,
    parameter int PIPE_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    cbfp1_min_ctrl_if.slave       bus
);

    localparam int CNT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BEATS - 1);

    logic [CNT_W-1:0]     beat_cnt;
    logic                 beat_first;
    logic                 beat_last;
    cbfp_tag_t            tag_in;
    cbfp_tag_t            tail;
    logic                 tag_busy;
    logic [LZC_WIDTH-1:0] acc_add;
    logic [LZC_WIDTH-1:0] acc_sub;
    logic [LZC_WIDTH-1:0] min_add;
    logic [LZC_WIDTH-1:0] min_sub;
    logic                 emit;
    logic                 blk_valid_q;
    logic [LZC_WIDTH-1:0] shift_add_q;
    logic [LZC_WIDTH-1:0] shift_sub_q;
    logic [7:0]           blk_idx_q;

    // With BLK_BEATS=1 the counter sits at 0 so every beat is first and last.
    assign beat_first = (beat_cnt == '0);
    assign beat_last  = (beat_cnt == CNT_LAST);

    // A beat presented together with clr is dropped, never tagged valid.
    assign tag_in = '{vld: bus.valid_in & ~clr, last: beat_last, first: beat_first};

    // Beat position inside the current block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (bus.valid_in) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        end
    end

    cbfp1_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .en       (bus.md_en),
        .tag_in   (tag_in),
        .tag_tail (tail),
        .any_vld  (tag_busy)
    );

    // Enable runs while beats arrive and until every in-flight tag has landed.
    assign bus.md_en = bus.valid_in | tag_busy;

    // Running minimum including the beat now at the datapath output; a first
    // beat restarts the fold, ties keep the already-held value.
    always_comb begin
        min_add = bus.md_min_add;
        min_sub = bus.md_min_sub;
        if (!tail.first) begin
            if (acc_add < bus.md_min_add) min_add = acc_add;
            if (acc_sub < bus.md_min_sub) min_sub = acc_sub;
        end
    end

    // Tail vld implies md_en is high, so the datapath output is fresh here.
    assign emit = tail.vld & tail.last & ~clr;

    // Per-block accumulators.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_add <= '0;
            acc_sub <= '0;
        end else if (clr) begin
            acc_add <= '0;
            acc_sub <= '0;
        end else if (tail.vld) begin
            acc_add <= min_add;
            acc_sub <= min_sub;
        end
    end

    // Block result registers; held across clr so the last result stays visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_valid_q <= 1'b0;
            shift_add_q <= '0;
            shift_sub_q <= '0;
        end else begin
            blk_valid_q <= emit;
            if (emit) begin
                shift_add_q <= min_add;
                shift_sub_q <= min_sub;
            end
        end
    end

    // Index advances once the pulse has been shown, so the pulse carries the
    // index of its own block; a block already emitted still consumes its index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_idx_q <= '0;
        end else if (blk_valid_q) begin
            blk_idx_q <= blk_idx_q + 8'd1;
        end
    end

    assign bus.blk_valid     = blk_valid_q;
    assign bus.blk_shift_add = shift_add_q;
    assign bus.blk_shift_sub = shift_sub_q;
    assign bus.blk_idx       = blk_idx_q;
    assign bus.busy          = tag_busy | (beat_cnt != '0);

endmodule
